wrr_table_builder: RTL and testbench
====================================

# wrr_table_builder

Configuration controller for `w_rndrobin`. It converts four per-channel weights into the 64-slot, 2-bit-per-slot priority table, then pulses `init` so the weighted round-robin loads the new table. The block sits between the configuration registers and `w_rndrobin`. Its `table_out` drives `w_rndrobin.tester_input` and its `init` drives `w_rndrobin.init`.

## Interface
- `NUM_VC`, 4: virtual channels. Fixed; the slot encoding depends on it.
- `SLOTS`, 64: table slots.
- `WEIGHT_W`, 7: weight width. Range 0..127.
- `clk0`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-low.
- `enb`  in  1  enable. 0 freezes FSM, counters and shadow table.
- `start`  in  1  build request; sampled in IDLE only.
- `weight_vc0`..`weight_vc3`  in  7 each  slot count per channel. The four weights must sum to exactly 64.
- `table_out`  out  128  committed table. Slot k is at bits [2k+1:2k].
- `init`  out  1  one-cycle load strobe to `w_rndrobin`.
- `busy`  out  1  high in CHECK, BUILD and INIT.
- `done`  out  1  one-cycle pulse, coincident with `init`.
- `cfg_error`  out  1  sticky weight-sum error. Cleared by the next accepted `start` or by reset.

## Operation
- States:
  - IDLE -> CHECK on `start`&&`enb`. Latches the weights into `rem[0..3]`, clears `slot` and sets `ptr`=0.
  - CHECK -> BUILD if the 9-bit sum == 64. Otherwise -> IDLE with `cfg_error`=1; `table_out` is untouched and no `init` is issued.
  - BUILD: one slot per cycle.
    - Pick the first i in the order `ptr`, `ptr`+1, … (mod 4) with `rem[i]`>0.
    - Write `shadow[slot]`=i, decrement `rem[i]`, set `ptr`=(i+1) mod 4 and increment `slot`.
    - After slot 63 is written -> INIT; `table_out` <= `shadow` on that edge.
  - INIT: `init`=1 and `done`=1 for one cycle -> IDLE.
- Zero-weight channels never appear in the table. A single weight of 64 fills all slots with that channel.
- `start` while `busy` is ignored and not queued.
- `enb`=0 holds state, `rem`, `ptr`, `slot` and `shadow`. `init` and `done` are forced 0 while `enb`=0. An INIT state stalled by `enb`=0 pulses once `enb` returns.
- Weights are latched at the `start` edge. Later weight changes do not affect the build in progress.

## Timing
- Reset values:
  - state IDLE; `rem`, `ptr`, `slot` = 0.
  - `busy`, `done`, `init`, `cfg_error` = 0.
  - `table_out` and `shadow` = default plain round robin, slot k = k mod 4.
- Reset mid-build aborts the build. The default table is restored, no `init` is issued, and `cfg_error` is cleared.
- `start` accepted at cycle T:
  - CHECK at T+1.
  - BUILD at T+2..T+65, with slot k written at the end of T+2+k.
  - `table_out` valid from T+66; INIT/`init`/`done` at T+66.
  - IDLE at T+67, where a new `start` can be accepted.
- Error path: `cfg_error` is high from T+2. `busy` is high only during T+1.
- `table_out` changes only at the BUILD->INIT edge or on reset. It is always stable during the `init` cycle.

## Structure
- Shared package `wrr_pkg` holds:
  - `NUM_VC`, `SLOTS`.
  - `SLOT_W`=2, `TABLE_W`=128.
  - The VCHANEL0..3 codes 2'b00..2'b11.
  - The state encoding IDLE/CHECK/BUILD/INIT.
  - The default-table constant.
- Sub-module `wrr_slot_picker` is combinational:
  - Inputs: `rem[0..3]` and `ptr`.
  - Outputs: `pick`[1:0] and `pick_valid`.
- The top level contains the FSM, counters and shadow and committed tables. The top level should be roughly 150–250 lines.

## Test plan
- Weights 16/16/16/16 -> `table_out` repeats 0,1,2,3 across all 64 slots. `init`=`done`=1 exactly at T+66, `busy` is high T+1..T+66, and `w_rndrobin` loads the table.
- Weights 32/16/8/8 -> slots 0–31 are 0,1,2,3 ×8, slots 32–47 are 0,1 ×8, and slots 48–63 are all 0.
- Weights 0/0/64/0 -> all slots = 2. Weights 20/20/20/3 (sum 63) -> `cfg_error`=1 at T+2, no `init`, and `table_out` keeps the previous value.
- `rst`=0 at T+30 -> next cycle: default table, `busy`=0, no `init`. A `start` pulsed at T+10 during the build is ignored.
- `enb`=0 for cycles T+20..T+24 -> `init` moves to T+71 and the table matches the unstalled case. Weights changed after T keep the latched values.

Source files
------------

// File: rtl/wrr_pkg.sv
// wrr_pkg: shared constants, channel codes, FSM encoding and default table
// for the weighted round-robin table builder.
package wrr_pkg;
    localparam int NUM_VC   = 4;
    localparam int SLOTS    = 64;
    localparam int SLOT_W   = 2;
    localparam int TABLE_W  = 128;
    localparam int WEIGHT_W = 7;

    localparam logic [SLOT_W-1:0] VCHANEL0 = 2'b00;
    localparam logic [SLOT_W-1:0] VCHANEL1 = 2'b01;
    localparam logic [SLOT_W-1:0] VCHANEL2 = 2'b10;
    localparam logic [SLOT_W-1:0] VCHANEL3 = 2'b11;

    typedef enum logic [1:0] {IDLE, CHECK, BUILD, INIT} state_t;

    // Plain round robin: slot k holds k mod 4.
    localparam logic [TABLE_W-1:0] DEFAULT_TABLE =
        {16{VCHANEL3, VCHANEL2, VCHANEL1, VCHANEL0}};
endpackage

// File: rtl/wrr_slot_picker.sv
// wrr_slot_picker: selects the first channel at or after ptr (mod 4)
// that still has slots remaining.
module wrr_slot_picker
    import wrr_pkg::*;
(
    input  logic [WEIGHT_W-1:0] rem [NUM_VC],
    input  logic [1:0]          ptr,
    output logic [1:0]          pick,
    output logic                pick_valid
);
    logic [1:0] idx;

    // Scan farthest-first so the candidate closest to ptr wins.
    always_comb begin
        pick       = VCHANEL0;
        pick_valid = 1'b0;
        idx        = '0;
        for (int j = NUM_VC - 1; j >= 0; j--) begin
            idx = ptr + 2'(j);
            if (rem[idx] != '0) begin
                pick       = idx;
                pick_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wrr_table_builder.sv
// wrr_table_builder: converts four channel weights into the 64-slot priority
// table for w_rndrobin and strobes init once the new table is committed.
module wrr_table_builder
    import wrr_pkg::*;
(
    input  logic                clk0,
    input  logic                rst,
    input  logic                enb,
    input  logic                start,
    input  logic [WEIGHT_W-1:0] weight_vc0,
    input  logic [WEIGHT_W-1:0] weight_vc1,
    input  logic [WEIGHT_W-1:0] weight_vc2,
    input  logic [WEIGHT_W-1:0] weight_vc3,
    output logic [TABLE_W-1:0]  table_out,
    output logic                init,
    output logic                busy,
    output logic                done,
    output logic                cfg_error
);
    state_t              state_q, state_d;
    logic [WEIGHT_W-1:0] rem_q [NUM_VC];
    logic [WEIGHT_W-1:0] rem_d [NUM_VC];
    logic [1:0]          ptr_q, ptr_d;
    logic [5:0]          slot_q, slot_d;
    logic [TABLE_W-1:0]  shadow_q, shadow_d;
    logic [TABLE_W-1:0]  table_q, table_d;
    logic                cfg_error_q, cfg_error_d;
    logic [1:0]          pick;
    logic                pick_valid;
    logic [8:0]          sum;

    wrr_slot_picker u_picker (
        .rem        (rem_q),
        .ptr        (ptr_q),
        .pick       (pick),
        .pick_valid (pick_valid)
    );

    assign sum       = 9'(rem_q[0]) + 9'(rem_q[1]) + 9'(rem_q[2]) + 9'(rem_q[3]);
    assign busy      = state_q != IDLE;
    assign init      = enb && state_q == INIT;
    assign done      = init;
    assign table_out = table_q;
    assign cfg_error = cfg_error_q;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        ptr_d       = ptr_q;
        slot_d      = slot_q;
        shadow_d    = shadow_q;
        table_d     = table_q;
        cfg_error_d = cfg_error_q;
        if (enb) begin
            case (state_q)
                IDLE: if (start) begin
                    state_d     = CHECK;
                    rem_d       = '{weight_vc0, weight_vc1, weight_vc2, weight_vc3};
                    ptr_d       = '0;
                    slot_d      = '0;
                    cfg_error_d = 1'b0;
                end
                CHECK: begin
                    state_d     = sum == 9'(SLOTS) ? BUILD : IDLE;
                    cfg_error_d = sum != 9'(SLOTS);
                end
                BUILD: begin
                    if (pick_valid) begin
                        shadow_d[{slot_q, 1'b0} +: SLOT_W] = pick;
                        rem_d[pick] = rem_q[pick] - WEIGHT_W'(1);
                        ptr_d       = pick + 2'd1;
                    end
                    slot_d = slot_q + 6'd1;
                    // Commit includes the final slot written on this same edge.
                    if (slot_q == 6'(SLOTS - 1)) begin
                        state_d = INIT;
                        table_d = shadow_d;
                    end
                end
                INIT: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk0) begin
        if (!rst) begin
            state_q     <= IDLE;
            rem_q       <= '{default: '0};
            ptr_q       <= '0;
            slot_q      <= '0;
            shadow_q    <= DEFAULT_TABLE;
            table_q     <= DEFAULT_TABLE;
            cfg_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            ptr_q       <= ptr_d;
            slot_q      <= slot_d;
            shadow_q    <= shadow_d;
            table_q     <= table_d;
            cfg_error_q <= cfg_error_d;
        end
    end
endmodule

// File: tb/tb_wrr_table_builder.sv
// tb_wrr_table_builder: directed checks of table building, error path,
// reset abort, enable stalls and weight latching.
module tb_wrr_table_builder;
    logic         clk0 = 1'b0;
    logic         rst, enb, start;
    logic [6:0]   w0, w1, w2, w3;
    logic [127:0] table_out;
    logic         init, busy, done, cfg_error;
    int           checks = 0;
    int           failures = 0;

    localparam logic [127:0] T_RR    = {16{8'hE4}};
    localparam logic [127:0] T_32168 = {32'h0, {4{8'h44}}, {8{8'hE4}}};
    localparam logic [127:0] T_VC2   = {16{8'hAA}};

    wrr_table_builder dut (
        .clk0       (clk0),
        .rst        (rst),
        .enb        (enb),
        .start      (start),
        .weight_vc0 (w0),
        .weight_vc1 (w1),
        .weight_vc2 (w2),
        .weight_vc3 (w3),
        .table_out  (table_out),
        .init       (init),
        .busy       (busy),
        .done       (done),
        .cfg_error  (cfg_error)
    );

    always #5 clk0 = ~clk0;

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkt(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_w(input logic [6:0] a, b, c, d);
        w0 = a; w1 = b; w2 = c; w3 = d;
    endtask

    initial begin
        rst = 1'b0; enb = 1'b1; start = 1'b0;
        set_w(0, 0, 0, 0);
        repeat (3) tick();
        chkt("rst_table", table_out, T_RR);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_init", init, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", cfg_error, 1'b0);
        rst = 1'b1;
        tick();

        // 16/16/16/16: busy T+1..T+66, init/done at T+66
        set_w(16, 16, 16, 16);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 65; c++) begin
            chk1("t1_busy", busy, 1'b1);
            chk1("t1_noinit", init, 1'b0);
            tick();
        end
        chk1("t1_init", init, 1'b1);
        chk1("t1_done", done, 1'b1);
        chk1("t1_busy66", busy, 1'b1);
        chkt("t1_table", table_out, T_RR);
        tick();
        chk1("t1_init67", init, 1'b0);
        chk1("t1_idle67", busy, 1'b0);

        // 32/16/8/8 with a stray start at T+10 that must be ignored
        set_w(32, 16, 8, 8);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 65; c++) begin
            tick();
            start = (c == 10);
        end
        chk1("t2_noinit65", init, 1'b0);
        tick();
        chk1("t2_init", init, 1'b1);
        chkt("t2_table", table_out, T_32168);
        tick();
        chk1("t2_idle", busy, 1'b0);

        // 0/0/64/0: every slot is channel 2
        set_w(0, 0, 64, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (65) tick();
        chk1("t3_init", init, 1'b1);
        chkt("t3_table", table_out, T_VC2);
        tick();

        // 20/20/20/3 sums to 63: error, no init, table kept
        set_w(20, 20, 20, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("t4_busy1", busy, 1'b1);
        chk1("t4_err1", cfg_error, 1'b0);
        tick();
        chk1("t4_err2", cfg_error, 1'b1);
        chk1("t4_busy2", busy, 1'b0);
        for (int c = 3; c <= 70; c++) begin
            chk1("t4_noinit", init, 1'b0);
            tick();
        end
        chk1("t4_sticky", cfg_error, 1'b1);
        chkt("t4_table", table_out, T_VC2);

        // Accepted start clears the error; reset at T+30 aborts the build
        set_w(16, 16, 16, 16);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("t5_errclr", cfg_error, 1'b0);
        for (int c = 2; c <= 30; c++) begin
            tick();
            start = (c == 10);
        end
        chk1("t5_busy30", busy, 1'b1);
        rst = 1'b0;
        tick();
        chkt("t5_table", table_out, T_RR);
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_init", init, 1'b0);
        chk1("t5_err", cfg_error, 1'b0);
        rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            chk1("t5_noinit", init, 1'b0);
        end

        // enb low T+20..T+24 shifts init to T+71; weights changed after T
        set_w(32, 16, 8, 8);
        start = 1'b1;
        tick();
        start = 1'b0;
        set_w(0, 0, 64, 0);
        for (int c = 2; c <= 70; c++) begin
            tick();
            chk1("t6_noinit", init, 1'b0);
            enb = !(c >= 20 && c <= 24);
        end
        chkt("t6_hold", table_out, T_RR);
        tick();
        chk1("t6_init", init, 1'b1);
        chk1("t6_done", done, 1'b1);
        chkt("t6_table", table_out, T_32168);
        tick();
        chk1("t6_init72", init, 1'b0);

        // enb low while in INIT suppresses the strobe until enb returns
        set_w(16, 16, 16, 16);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (65) tick();
        enb = 1'b0;
        #1;
        chk1("t7_init_off", init, 1'b0);
        chk1("t7_done_off", done, 1'b0);
        chk1("t7_busy", busy, 1'b1);
        tick();
        chk1("t7_init_off2", init, 1'b0);
        enb = 1'b1;
        #1;
        chk1("t7_init_on", init, 1'b1);
        chkt("t7_table", table_out, T_RR);
        tick();
        chk1("t7_init_end", init, 1'b0);
        chk1("t7_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
